// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ clients.
// Optional zero register (index all-ones reads as 0) when REGFILE_RD_ZERO_EN is defined.
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic               stall,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      mux_sel,
  input  logic [DW-1:0]      mux_data,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [AW-1:0]   addr_a [NREQ];
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand_idx;
  logic            found;
  logic            grant_en;
  int unsigned     cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_a[g] = req_addr[g*AW +: AW];
  end

  // Scan from ptr upward with wrap; first requester encountered wins.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_q) + k) % NREQ;
      cand_idx = cand[PW-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign grant_en = found & ~stall;

  always_comb begin
    gnt     = '0;
    mux_sel = '0;
    if (grant_en) begin
      gnt[win] = 1'b1;
      mux_sel  = addr_a[win];
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (grant_en) begin
      ptr_d    = (win == LAST) ? '0 : win + PW'(1);
      rvalid_d = gnt;
`ifdef REGFILE_RD_ZERO_EN
      rdata_d  = (mux_sel == '1) ? '0 : mux_data;
`else
      rdata_d  = mux_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (NREQ=4, AW=5, DW=32).
module tb_regfile_read_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic        stall;
  logic [3:0]  gnt;
  logic [4:0]  mux_sel;
  logic [31:0] mux_data;
  logic [3:0]  rvalid;
  logic [31:0] rdata;

  int compared;
  int mismatched;

  logic [3:0]  exp_g;
  logic [3:0]  prev_g;
  logic [31:0] prev_d;

  regfile_read_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .stall    (stall),
    .gnt      (gnt),
    .mux_sel  (mux_sel),
    .mux_data (mux_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    req        = '0;
    req_addr   = '0;
    stall      = 1'b0;
    mux_data   = '0;

    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_gnt_idle", 32'(gnt), 32'h0);

    // Single client 2, index 5
    cyc();
    reset_n  = 1'b1;
    req      = 4'b0100;
    req_addr = 20'(5) << 10;
    mux_data = 32'hDEADBEEF;
    #1;
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(mux_sel), 32'd5);
    cyc();
    req = '0;
    mux_data = 32'h0BAD0BAD;
    #1;
    chk("single_rvalid", 32'(rvalid), 32'h4);
    chk("single_rdata", rdata, 32'hDEADBEEF);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_sel", 32'(mux_sel), 32'h0);
    cyc();
    #1;
    chk("idle_rvalid", 32'(rvalid), 32'h0);
    chk("idle_rdata_hold", rdata, 32'hDEADBEEF);

    // ptr=3 now: all requesting picks client 3, then reset mid-run
    cyc();
    req      = 4'b1111;
    req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    mux_data = 32'hAAAA0000;
    #1;
    chk("pre_rst_gnt", 32'(gnt), 32'h8);
    cyc();
    #1;
    chk("pre_rst_rvalid", 32'(rvalid), 32'h8);
    chk("pre_rst_rdata", rdata, 32'hAAAA0000);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h1);
    cyc();
    #1;
    chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
    chk("rst_hold_rdata", rdata, 32'h0);

    // Round-robin with all four requesting, 8 grants
    prev_g = '0;
    prev_d = '0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      reset_n  = 1'b1;
      mux_data = 32'hC0DE0000 + 32'(c);
      exp_g    = 4'b0001 << (c % 4);
      #1;
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_sel", 32'(mux_sel), 32'(10 + (c % 4)));
      if (c > 0) begin
        chk("rr_rvalid", 32'(rvalid), 32'(prev_g));
        chk("rr_rdata", rdata, prev_d);
      end
      prev_g = exp_g;
      prev_d = mux_data;
    end
    cyc();
    req = '0;
    #1;
    chk("rr_wrap_rvalid", 32'(rvalid), 32'h8);
    chk("rr_wrap_rdata", rdata, 32'hC0DE0007);

    // Withdrawal: client 1 requests only while client 0 wins
    cyc();
    req = 4'b0011;
    mux_data = 32'h11110000;
    #1;
    chk("wd_gnt", 32'(gnt), 32'h1);
    cyc();
    req = '0;
    #1;
    chk("wd_rvalid0", 32'(rvalid), 32'h1);
    cyc();
    #1;
    chk("wd_no_rvalid1", 32'(rvalid), 32'h0);
    req = 4'b0011;
    #1;
    chk("wd_ptr_is_1", 32'(gnt), 32'h2);
    cyc();
    req = '0;
    #1;
    chk("wd_rvalid_new", 32'(rvalid), 32'h2);

    // Stall for 3 cycles with ptr=2
    for (int s = 0; s < 3; s++) begin
      cyc();
      req   = 4'b0011;
      stall = 1'b1;
      #1;
      chk("stall_gnt", 32'(gnt), 32'h0);
      chk("stall_sel", 32'(mux_sel), 32'h0);
      if (s > 0) chk("stall_rvalid", 32'(rvalid), 32'h0);
    end
    cyc();
    stall = 1'b0;
    mux_data = 32'h22220000;
    #1;
    chk("unstall_gnt", 32'(gnt), 32'h1);
    chk("unstall_sel", 32'(mux_sel), 32'd10);
    chk("stall_rvalid_end", 32'(rvalid), 32'h0);

    // Zero-register index from client 1 (ptr=1)
    cyc();
    req      = 4'b0010;
    req_addr = 20'(31) << 5;
    mux_data = 32'h12345678;
    #1;
    chk("zr_gnt", 32'(gnt), 32'h2);
    chk("zr_sel", 32'(mux_sel), 32'd31);
    chk("unstall_rvalid", 32'(rvalid), 32'h1);
    chk("unstall_rdata", rdata, 32'h22220000);
    cyc();
    req = '0;
    #1;
    chk("zr_rvalid", 32'(rvalid), 32'h2);
`ifdef REGFILE_RD_ZERO_EN
    chk("zr_rdata", rdata, 32'h0);
`else
    chk("zr_rdata", rdata, 32'h12345678);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
